// File: rtl/ahb_fir_pkg.sv
// Shared constants, loader state type and byte-lane merge helper for the
// AHB-Lite front end of the FIR filter.
package ahb_fir_pkg;

    localparam logic [3:0] ADDR_STATUS = 4'h0;
    localparam logic [3:0] ADDR_RESULT = 4'h2;
    localparam logic [3:0] ADDR_SAMPLE = 4'h4;
    localparam logic [3:0] ADDR_F0     = 4'h6;
    localparam logic [3:0] ADDR_F1     = 4'h8;
    localparam logic [3:0] ADDR_F2     = 4'hA;
    localparam logic [3:0] ADDR_F3     = 4'hC;
    localparam logic [3:0] ADDR_LOAD   = 4'hE;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        LOAD0, WAIT0,
        LOAD1, WAIT1,
        LOAD2, WAIT2,
        LOAD3, WAIT3
    } loader_state_t;

    // Byte writes replace only the lane picked by the low address bit;
    // halfword writes replace the whole register.
    function automatic logic [15:0] mergeWrite(input logic [15:0] oldVal,
                                               input logic [15:0] newVal,
                                               input logic [1:0]  size,
                                               input logic        upperLane);
        logic [15:0] merged;
        merged = newVal;
        if (size == 2'd0) begin
            merged = upperLane ? {newVal[15:8], oldVal[7:0]}
                               : {oldVal[15:8], newVal[7:0]};
        end
        return merged;
    endfunction

endpackage

// File: rtl/coeff_loader.sv
// Walks the four coefficients into the filter, one load_coeff pulse each,
// waiting for the filter to drop modwait before presenting the next one.
module coeff_loader
    import ahb_fir_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [15:0] coeff0,
    input  logic [15:0] coeff1,
    input  logic [15:0] coeff2,
    input  logic [15:0] coeff3,
    input  logic        modwait,
    output logic        load_coeff,
    output logic [15:0] fir_coefficient,
    output logic        active,
    output logic        done
);

    loader_state_t state_q, state_d;

    // State register; reset drops straight back to IDLE mid-sequence.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Each LOAD lasts one cycle; each WAIT holds until the filter is free.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD0;
            LOAD0:   state_d = WAIT0;
            WAIT0:   if (!modwait) state_d = LOAD1;
            LOAD1:   state_d = WAIT1;
            WAIT1:   if (!modwait) state_d = LOAD2;
            LOAD2:   state_d = WAIT2;
            WAIT2:   if (!modwait) state_d = LOAD3;
            LOAD3:   state_d = WAIT3;
            WAIT3:   if (!modwait) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode purely from the state so reset removes load_coeff at once.
    always_comb begin
        load_coeff      = 1'b0;
        fir_coefficient = 16'h0000;
        active          = (state_q != IDLE);
        done            = (state_q == WAIT3) && !modwait;
        case (state_q)
            LOAD0: begin load_coeff = 1'b1; fir_coefficient = coeff0; end
            LOAD1: begin load_coeff = 1'b1; fir_coefficient = coeff1; end
            LOAD2: begin load_coeff = 1'b1; fir_coefficient = coeff2; end
            LOAD3: begin load_coeff = 1'b1; fir_coefficient = coeff3; end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_fir_slave.sv
// AHB-Lite register front end for one fir_filter: holds sample and
// coefficients, paces data_ready / load_coeff on modwait, returns results.
module ahb_fir_slave
    import ahb_fir_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        hsel,
    input  logic [3:0]  haddr,
    input  logic [1:0]  hsize,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [15:0] hwdata,
    output logic [15:0] hrdata,
    output logic        hready,
    output logic        hresp,
    input  logic        modwait,
    input  logic [15:0] fir_out,
    input  logic        err,
    output logic [15:0] sample_data,
    output logic [15:0] fir_coefficient,
    output logic        data_ready,
    output logic        load_coeff
);

    logic        dphValid_q, dphWrite_q;
    logic [3:0]  dphAddr_q;
    logic [1:0]  dphSize_q;
    logic        errSecond_q;
    logic [15:0] sample_q, f0_q, f1_q, f2_q, f3_q, result_q;
    logic        loadBit_q, pending_q, resultValid_q, errSticky_q, modwaitPrev_q;

    logic        addrAccept, illegal, dphErr, wrLegal, rdLegal;
    logic        loaderActive, loaderDone, startLoad, modwaitFall, busy, dataReady;
    logic [3:0]  regSel;
    logic [15:0] readMux, wrValue;

    assign addrAccept  = hsel && hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    assign regSel      = {dphAddr_q[3:1], 1'b0};
    assign illegal     = dphSize_q[1]
                      || ((dphSize_q == 2'd1) && dphAddr_q[0])
                      || (dphWrite_q && ((regSel == ADDR_STATUS) || (regSel == ADDR_RESULT)));
    assign dphErr      = dphValid_q && illegal;
    assign wrLegal     = dphValid_q && dphWrite_q && !illegal;
    assign rdLegal     = dphValid_q && !dphWrite_q && !illegal;
    assign hready      = !(dphErr && !errSecond_q);
    assign hresp       = dphErr;
    assign hrdata      = rdLegal ? readMux : 16'h0000;
    assign wrValue     = mergeWrite(readMux, hwdata, dphSize_q, dphAddr_q[0]);
    assign startLoad   = loadBit_q || (wrLegal && (regSel == ADDR_LOAD) && wrValue[0]);
    assign modwaitFall = modwaitPrev_q && !modwait;
    assign busy        = modwait || loaderActive || pending_q;
    assign dataReady   = pending_q && !loaderActive && !modwait;
    assign data_ready  = dataReady;
    assign sample_data = sample_q;

    // Register the address phase; it is frozen while the bus is stalled.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dphValid_q <= 1'b0;
            dphWrite_q <= 1'b0;
            dphAddr_q  <= 4'h0;
            dphSize_q  <= 2'd0;
        end else if (hready) begin
            dphValid_q <= addrAccept;
            dphWrite_q <= hwrite;
            dphAddr_q  <= haddr;
            dphSize_q  <= hsize;
        end
    end

    // Marks the second cycle of the two-cycle ERROR response.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            errSecond_q <= 1'b0;
        end else begin
            errSecond_q <= dphErr && !errSecond_q;
        end
    end

    // Current contents of the addressed register, also the base for byte merges.
    always_comb begin
        readMux = 16'h0000;
        case (regSel)
            ADDR_STATUS: readMux = {13'b0, errSticky_q, resultValid_q, busy};
            ADDR_RESULT: readMux = result_q;
            ADDR_SAMPLE: readMux = sample_q;
            ADDR_F0:     readMux = f0_q;
            ADDR_F1:     readMux = f1_q;
            ADDR_F2:     readMux = f2_q;
            ADDR_F3:     readMux = f3_q;
            ADDR_LOAD:   readMux = {15'b0, loadBit_q};
            default:     readMux = 16'h0000;
        endcase
    end

    // Writable registers; a LOAD write in the same cycle as completion wins.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sample_q  <= 16'h0000;
            f0_q      <= 16'h0000;
            f1_q      <= 16'h0000;
            f2_q      <= 16'h0000;
            f3_q      <= 16'h0000;
            loadBit_q <= 1'b0;
        end else begin
            if (wrLegal && (regSel == ADDR_SAMPLE)) sample_q <= wrValue;
            if (wrLegal && (regSel == ADDR_F0))     f0_q     <= wrValue;
            if (wrLegal && (regSel == ADDR_F1))     f1_q     <= wrValue;
            if (wrLegal && (regSel == ADDR_F2))     f2_q     <= wrValue;
            if (wrLegal && (regSel == ADDR_F3))     f3_q     <= wrValue;
            if (wrLegal && (regSel == ADDR_LOAD)) begin
                loadBit_q <= wrValue[0];
            end else if (loaderDone) begin
                loadBit_q <= 1'b0;
            end
        end
    end

    // A sample write arms one data_ready pulse, issued once the filter is free.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pending_q <= 1'b0;
        end else if (wrLegal && (regSel == ADDR_SAMPLE)) begin
            pending_q <= 1'b1;
        end else if (dataReady) begin
            pending_q <= 1'b0;
        end
    end

    // Latch the filter result when modwait falls; sticky error flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            modwaitPrev_q <= 1'b0;
            result_q      <= 16'h0000;
            resultValid_q <= 1'b0;
            errSticky_q   <= 1'b0;
        end else begin
            modwaitPrev_q <= modwait;
            errSticky_q   <= errSticky_q || err;
            if (modwaitFall) begin
                result_q      <= fir_out;
                resultValid_q <= 1'b1;
            end else if (rdLegal && (regSel == ADDR_RESULT)) begin
                resultValid_q <= 1'b0;
            end
        end
    end

    coeff_loader uLoader (
        .clk             (clk),
        .n_rst           (n_rst),
        .start           (startLoad),
        .coeff0          (f0_q),
        .coeff1          (f1_q),
        .coeff2          (f2_q),
        .coeff3          (f3_q),
        .modwait         (modwait),
        .load_coeff      (load_coeff),
        .fir_coefficient (fir_coefficient),
        .active          (loaderActive),
        .done            (loaderDone)
    );

endmodule

// File: tb/tb_ahb_fir_slave.sv
// Self-checking bench for ahb_fir_slave: directed register-map scenarios
// followed by randomized bus traffic checked against a register-array model.
module tb_ahb_fir_slave;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        hsel = 1'b0;
    logic [3:0]  haddr = 4'h0;
    logic [1:0]  hsize = 2'd0;
    logic [1:0]  htrans = 2'd0;
    logic        hwrite = 1'b0;
    logic [15:0] hwdata = 16'h0000;
    logic [15:0] hrdata;
    logic        hready, hresp;
    logic        modwait = 1'b0;
    logic [15:0] fir_out = 16'h0000;
    logic        err = 1'b0;
    logic [15:0] sample_data, fir_coefficient;
    logic        data_ready, load_coeff;

    int checkCount = 0;
    int errorCount = 0;

    // Register model indexed by byte address / 2.
    logic [15:0] model [8];

    ahb_fir_slave dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .hsel            (hsel),
        .haddr           (haddr),
        .hsize           (hsize),
        .htrans          (htrans),
        .hwrite          (hwrite),
        .hwdata          (hwdata),
        .hrdata          (hrdata),
        .hready          (hready),
        .hresp           (hresp),
        .modwait         (modwait),
        .fir_out         (fir_out),
        .err             (err),
        .sample_data     (sample_data),
        .fir_coefficient (fir_coefficient),
        .data_ready      (data_ready),
        .load_coeff      (load_coeff)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, observed, expected);
        end
    endtask

    // One non-pipelined transfer; called and returns just after a rising edge.
    task automatic applyStimulus(input logic [3:0] addr, input logic [1:0] size, input logic write,
                                 input logic [15:0] wdata, input logic expErr, output logic [15:0] rdata);
        hsel = 1'b1; haddr = addr; hsize = size; htrans = 2'b10; hwrite = write;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wdata;
        @(negedge clk);
        rdata = hrdata;
        if (expErr) begin
            checkOutput("err cycle1 hready", 16'(hready), 16'h0);
            checkOutput("err cycle1 hresp", 16'(hresp), 16'h1);
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("err cycle2 hready", 16'(hready), 16'h1);
            checkOutput("err cycle2 hresp", 16'(hresp), 16'h1);
        end else begin
            checkOutput("okay hready", 16'(hready), 16'h1);
            checkOutput("okay hresp", 16'(hresp), 16'h0);
        end
        @(posedge clk); #1;
    endtask

    task automatic busWrite(input logic [3:0] addr, input logic [15:0] wdata);
        logic [15:0] rd;
        applyStimulus(addr, 2'd1, 1'b1, wdata, 1'b0, rd);
    endtask

    task automatic busRead(input logic [3:0] addr, input string tag, input logic [15:0] expected);
        logic [15:0] rd;
        applyStimulus(addr, 2'd1, 1'b0, 16'h0000, 1'b0, rd);
        checkOutput(tag, rd, expected);
    endtask

    initial begin
        logic [15:0] seen [$];
        logic [15:0] rd, wd;
        logic [2:0]  idx;
        logic        lane;
        int          mwCnt, drCount, op, pos;

        // Reset state
        #12;
        checkOutput("reset hrdata", hrdata, 16'h0000);
        checkOutput("reset hready", 16'(hready), 16'h1);
        checkOutput("reset hresp", 16'(hresp), 16'h0);
        checkOutput("reset data_ready", 16'(data_ready), 16'h0);
        checkOutput("reset load_coeff", 16'(load_coeff), 16'h0);
        checkOutput("reset sample_data", sample_data, 16'h0000);
        checkOutput("reset fir_coefficient", fir_coefficient, 16'h0000);
        @(posedge clk); #1;
        n_rst = 1'b1;
        busRead(4'h0, "status after reset", 16'h0000);

        // Coefficient load with a filter that stays busy 3 cycles per coefficient
        busWrite(4'h6, 16'h0001);
        busWrite(4'h8, 16'h0002);
        busWrite(4'hA, 16'h0003);
        busWrite(4'hC, 16'h0004);
        busWrite(4'hE, 16'h0001);
        mwCnt = 0;
        drCount = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (cyc == 0) checkOutput("LOAD0 one cycle after write", 16'(load_coeff), 16'h1);
            if (load_coeff) begin
                seen.push_back(fir_coefficient);
                mwCnt = 3;
            end
            if (data_ready) drCount++;
            @(posedge clk); #1;
            modwait = (mwCnt > 0);
            if (mwCnt > 0) mwCnt--;
        end
        checkOutput("load_coeff pulse count", 16'(seen.size()), 16'd4);
        while (seen.size() < 4) seen.push_back(16'hFFFF);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("coefficient %0d", i), seen[i], 16'(i + 1));
        end
        checkOutput("no data_ready during load", 16'(drCount), 16'd0);
        busRead(4'hE, "LOAD self-cleared", 16'h0000);
        busRead(4'h0, "status after load", 16'h0002);
        busRead(4'h2, "result after load", 16'h0000);
        busRead(4'h0, "status valid cleared", 16'h0000);

        // Sample handshake held off by modwait, two writes give one pulse
        modwait = 1'b1;
        @(posedge clk); #1;
        busWrite(4'h4, 16'h1111);
        busWrite(4'h4, 16'h1234);
        busRead(4'h0, "status busy", 16'h0001);
        fir_out = 16'h00AB;
        drCount = 0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            if (data_ready) drCount++;
            @(posedge clk); #1;
        end
        checkOutput("data_ready held while busy", 16'(drCount), 16'd0);
        modwait = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (data_ready) begin
                drCount++;
                checkOutput("sample_data at data_ready", sample_data, 16'h1234);
            end
            @(posedge clk); #1;
        end
        checkOutput("data_ready pulse count", 16'(drCount), 16'd1);
        busRead(4'h0, "status result_valid", 16'h0002);
        busRead(4'h2, "result latched", 16'h00AB);
        busRead(4'h0, "status after result read", 16'h0000);

        // Error responses leave registers untouched
        applyStimulus(4'h2, 2'd1, 1'b1, 16'hFFFF, 1'b1, rd);
        busRead(4'h2, "result after bad write", 16'h00AB);
        applyStimulus(4'h4, 2'd2, 1'b0, 16'h0000, 1'b1, rd);
        applyStimulus(4'h4, 2'd2, 1'b1, 16'hFFFF, 1'b1, rd);
        busRead(4'h4, "sample after bad size", 16'h1234);
        applyStimulus(4'h7, 2'd1, 1'b1, 16'hFFFF, 1'b1, rd);
        busRead(4'h6, "F0 after odd halfword", 16'h0001);

        // Sticky error survives a STATUS write
        err = 1'b1;
        @(posedge clk); #1;
        err = 1'b0;
        busRead(4'h0, "status err sticky", 16'h0004);
        applyStimulus(4'h0, 2'd1, 1'b1, 16'h0000, 1'b1, rd);
        busRead(4'h0, "status err after write", 16'h0004);

        // Byte lane write and back-to-back write/read forwarding
        applyStimulus(4'h5, 2'd0, 1'b1, 16'hCDCD, 1'b0, rd);
        busRead(4'h4, "byte write upper lane", 16'hCD34);
        hsel = 1'b1; haddr = 4'hA; hsize = 2'd1; htrans = 2'b10; hwrite = 1'b1;
        @(posedge clk); #1;
        hwdata = 16'h5A5A; hwrite = 1'b0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        checkOutput("write then read forward", hrdata, 16'h5A5A);
        @(posedge clk); #1;

        // Reset in the middle of a load drops load_coeff immediately
        busWrite(4'hE, 16'h0001);
        @(negedge clk);
        checkOutput("load_coeff before reset", 16'(load_coeff), 16'h1);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("load_coeff async drop", 16'(load_coeff), 16'h0);
        checkOutput("fir_coefficient in reset", fir_coefficient, 16'h0000);
        @(posedge clk); #1;
        n_rst = 1'b1;
        busRead(4'hE, "LOAD after reset", 16'h0000);
        busRead(4'h6, "F0 after reset", 16'h0000);
        busRead(4'h0, "status after reset 2", 16'h0000);

        // Randomized traffic against the register model
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        for (int it = 0; it < 80; it++) begin
            idx  = 3'($urandom_range(6, 2));
            lane = 1'($urandom_range(1, 0));
            op   = int'($urandom_range(3, 0));
            wd   = 16'($urandom);
            case (op)
                0: begin
                    applyStimulus({idx, 1'b0}, 2'd1, 1'b1, wd, 1'b0, rd);
                    model[idx] = wd;
                end
                1: begin
                    applyStimulus({idx, lane}, 2'd0, 1'b1, wd, 1'b0, rd);
                    pos = lane ? 8 : 0;
                    model[idx] = (model[idx] & ~(16'h00FF << pos)) | (wd & (16'h00FF << pos));
                end
                2: begin
                    busRead({idx, 1'b0}, $sformatf("random read reg%0d", idx), model[idx]);
                end
                default: begin
                    if (lane)
                        applyStimulus({idx, 1'b1}, 2'd1, wd[0], wd, 1'b1, rd);
                    else
                        applyStimulus({idx, 1'b0}, 2'($urandom_range(3, 2)), wd[0], wd, 1'b1, rd);
                end
            endcase
        end
        for (int r = 2; r <= 6; r++) begin
            idx = 3'(r);
            busRead({idx, 1'b0}, $sformatf("final reg%0d", r), model[idx]);
        end
        checkOutput("sample_data tracks SAMPLE", sample_data, model[2]);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
